// File: rtl/nios_jsm_pkg.sv
// -----------------------------------------------------------------------------
// nios_jsm_pkg
// Shared definitions for the Nios II virtual-JTAG scan master:
//   - jsm_state_e   : scan sequencer states
//   - DEF_*         : default parameter values for the scan master
//   - scan_periods(): number of TCK periods in one complete scan
// -----------------------------------------------------------------------------
package nios_jsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_DONE
    } jsm_state_e;

    localparam int DEF_TCK_DIV    = 2;
    localparam int DEF_DR_WIDTH   = 38;
    localparam int DEF_IR_WIDTH   = 2;
    localparam int DEF_RTI_CYCLES = 1;

    // UIR + CDR + UDR, one period per data bit, RTI periods; UIR drops out
    // when the instruction is already loaded.
    function automatic int scan_periods(input int dr_width, input int rti_cycles,
                                        input logic skip_uir);
        return 3 + dr_width + rti_cycles - (skip_uir ? 1 : 0);
    endfunction

endpackage

// File: rtl/nios_jsm_tck_gen.sv
// -----------------------------------------------------------------------------
// nios_jsm_tck_gen
// Divided TCK generator. Each TCK period is TCK_DIV clk cycles low followed by
// TCK_DIV clk cycles high, starting low when enabled.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   en         : run TCK; when low TCK is forced low and the divider cleared
//   tck        : registered TCK output
//   rise       : high in the clk cycle whose closing edge drives TCK high
//   fall       : high in the clk cycle whose closing edge drives TCK low
//                (end of a TCK period)
// -----------------------------------------------------------------------------
module nios_jsm_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int PERIOD = 2 * TCK_DIV;
    localparam int CW     = $clog2(PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;

    always_comb begin
        cnt_d = '0;
        tck_d = 1'b0;
        if (en) begin
            if (cnt_q == CW'(PERIOD - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            // Second half of the period is the high phase.
            tck_d = (cnt_d >= CW'(TCK_DIV));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck  = tck_q;
    assign rise = en && (cnt_q == CW'(TCK_DIV - 1));
    assign fall = en && (cnt_q == CW'(PERIOD - 1));

endmodule

// File: rtl/nios_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// nios_jtag_scan_master
// Host-side initiator for the Nios II virtual-JTAG debug port. Accepts one
// command (instruction + data word), walks UIR, CDR, SDR, UDR, RTI with a
// divided TCK, shifts the data word out LSB first on vji_tdi and captures
// vji_tdo into rsp_data.
// Ports:
//   clk, reset            : system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_ir, cmd_dr        : instruction and data word of the command
//   rsp_valid, rsp_data   : one-cycle completion pulse, captured TDO word
//   busy                  : scan in progress
//   vji_tck/tdi/tdo       : virtual JTAG clock and serial data
//   vji_ir_in             : instruction presented to the debug module
//   vji_uir..vji_rti      : one-hot virtual-state flags
// Build option: NIOS_JSM_IR_CACHE_EN - skip UIR when the requested
// instruction is already loaded.
// -----------------------------------------------------------------------------
module nios_jtag_scan_master
    import nios_jsm_pkg::*;
#(
    parameter int TCK_DIV    = DEF_TCK_DIV,
    parameter int DR_WIDTH   = DEF_DR_WIDTH,
    parameter int IR_WIDTH   = DEF_IR_WIDTH,
    parameter int RTI_CYCLES = DEF_RTI_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int BW = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;
    localparam int RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

    jsm_state_e          state_q, state_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [DR_WIDTH-1:0] cap_q, cap_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [RW-1:0]       rti_q, rti_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                tdi_q, tdi_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic [4:0]          flags_q, flags_d;   // {uir, cdr, sdr, udr, rti}

    logic tck_en, tck_rise, tck_fall;
    logic accept, skip_uir;

    assign accept = (state_q == ST_IDLE) && cmd_valid;
    assign tck_en = (state_q == ST_UIR) || (state_q == ST_CDR) || (state_q == ST_SDR) ||
                    (state_q == ST_UDR) || (state_q == ST_RTI);

    nios_jsm_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk   (clk),
        .reset (reset),
        .en    (tck_en),
        .tck   (vji_tck),
        .rise  (tck_rise),
        .fall  (tck_fall)
    );

`ifdef NIOS_JSM_IR_CACHE_EN
    // ir_q doubles as the cached instruction; the valid bit says whether the
    // debug module has actually been loaded with it since reset.
    logic ir_vld_q, ir_vld_d;

    assign skip_uir = ir_vld_q && (cmd_ir == ir_q);

    always_comb begin
        ir_vld_d = ir_vld_q | accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_vld_q <= 1'b0;
        end else begin
            ir_vld_q <= ir_vld_d;
        end
    end
`else
    assign skip_uir = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        bit_d       = bit_q;
        rti_d       = rti_q;
        ir_d        = ir_q;
        tdi_d       = tdi_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sr_d    = cmd_dr;
                    ir_d    = cmd_ir;
                    bit_d   = '0;
                    rti_d   = '0;
                    tdi_d   = 1'b0;
                    state_d = skip_uir ? ST_CDR : ST_UIR;
                end
            end
            ST_UIR: begin
                if (tck_fall) state_d = ST_CDR;
            end
            ST_CDR: begin
                // Bit 0 goes out on the falling edge that opens SDR.
                if (tck_fall) begin
                    state_d = ST_SDR;
                    tdi_d   = sr_q[0];
                    sr_d    = sr_q >> 1;
                end
            end
            ST_SDR: begin
                if (tck_rise) begin
                    cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
                end
                if (tck_fall) begin
                    if (bit_q == BW'(DR_WIDTH - 1)) begin
                        state_d = ST_UDR;
                        tdi_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tdi_d = sr_q[0];
                        sr_d  = sr_q >> 1;
                    end
                end
            end
            ST_UDR: begin
                if (tck_fall) state_d = ST_RTI;
            end
            ST_RTI: begin
                if (tck_fall) begin
                    if (rti_q == RW'(RTI_CYCLES - 1)) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cap_q;
                    end else begin
                        rti_d = rti_q + RW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        flags_d     = {state_d == ST_UIR, state_d == ST_CDR, state_d == ST_SDR,
                       state_d == ST_UDR, state_d == ST_RTI};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            bit_q       <= '0;
            rti_q       <= '0;
            ir_q        <= '0;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            bit_q       <= bit_d;
            rti_q       <= rti_d;
            ir_q        <= ir_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            flags_q     <= flags_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign vji_uir   = flags_q[4];
    assign vji_cdr   = flags_q[3];
    assign vji_sdr   = flags_q[2];
    assign vji_udr   = flags_q[1];
    assign vji_rti   = flags_q[0];

endmodule

// File: tb/tb_nios_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// tb_nios_jtag_scan_master
// Self-checking bench: a default-parameter scan master (TDO driven from a
// selectable source) and a TCK_DIV=1 instance (TDO looped to TDI) used for
// flag-timing checks. Expected latencies and data come from a small model of
// the scan rules kept in this file.
// -----------------------------------------------------------------------------
module tb_nios_jtag_scan_master;

    localparam int W      = 38;
    localparam int P      = 4;             // clk cycles per TCK period, TCK_DIV=2
`ifdef NIOS_JSM_IR_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_ir = '0;
    logic [W-1:0] cmd_dr = '0;
    logic         cmd_ready, rsp_valid, busy;
    logic [W-1:0] rsp_data;
    logic         vji_tck, vji_tdi, vji_tdo;
    logic [1:0]   vji_ir_in;
    logic         vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    int           tdo_mode = 0;

    logic         c1_valid = 1'b0;
    logic [1:0]   c1_ir = '0;
    logic [W-1:0] c1_dr = '0;
    logic         c1_ready, r1_valid, busy_1;
    logic [W-1:0] r1_data;
    logic         tck_1, tdi_1, tdo_1;
    logic [1:0]   ir_in_1;
    logic         uir_1, cdr_1, sdr_1, udr_1, rti_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // TDO source: 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low.
    assign vji_tdo = (tdo_mode == 0) ? vji_tdi :
                     (tdo_mode == 1) ? ~vji_tdi :
                     (tdo_mode == 2) ? 1'b1 : 1'b0;
    assign tdo_1   = tdi_1;

    nios_jtag_scan_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    nios_jtag_scan_master #(.TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_dr(c1_dr),
        .rsp_valid(r1_valid), .rsp_data(r1_data), .busy(busy_1),
        .vji_tck(tck_1), .vji_tdi(tdi_1), .vji_tdo(tdo_1), .vji_ir_in(ir_in_1),
        .vji_uir(uir_1), .vji_cdr(cdr_1), .vji_sdr(sdr_1), .vji_udr(udr_1),
        .vji_rti(rti_1)
    );

    // ---------------- observation ----------------
    logic [W-1:0] tdi_seq;
    int tdi_n, rise_n, tdi_one_n, ovl_n, ovl1_n;
    int fl_n[5];
    int fl1_n[5];

    always @(posedge vji_tck) begin
        rise_n++;
        if (vji_sdr) begin
            if (tdi_n < W) tdi_seq[tdi_n] = vji_tdi;
            tdi_n++;
        end
    end

    always @(negedge clk) begin
        if (vji_uir) fl_n[0]++;
        if (vji_cdr) fl_n[1]++;
        if (vji_sdr) fl_n[2]++;
        if (vji_udr) fl_n[3]++;
        if (vji_rti) fl_n[4]++;
        if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) ovl_n++;
        if (vji_sdr && vji_tdi) tdi_one_n++;
        if (uir_1) fl1_n[0]++;
        if (cdr_1) fl1_n[1]++;
        if (sdr_1) fl1_n[2]++;
        if (udr_1) fl1_n[3]++;
        if (rti_1) fl1_n[4]++;
        if ($countones({uir_1, cdr_1, sdr_1, udr_1, rti_1}) > 1) ovl1_n++;
    end

    // ---------------- reference model ----------------
    bit         m_vld = 1'b0;
    logic [1:0] m_ir  = '0;

    // Periods a command will take, given what instruction is already loaded.
    task automatic model_accept(input logic [1:0] ir, output int periods);
        periods = 3 + W + 1;
        if (CACHE_EN && m_vld && (ir == m_ir)) periods = periods - 1;
        m_ir  = ir;
        m_vld = 1'b1;
    endtask

    function automatic logic [W-1:0] exp_data(input logic [W-1:0] dr, input int mode);
        case (mode)
            0:       return dr;
            1:       return ~dr;
            2:       return '1;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_dr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Issue one command on the main DUT (caller is #1 after an edge, DUT idle),
    // return clk count from accept edge to rsp_valid (-1 on timeout).
    task automatic run_scan(input logic [1:0] ir, input logic [W-1:0] dr, input int mode,
                            output int lat, output logic [W-1:0] data);
        tdo_mode  = mode;
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        tdi_n = 0; tdi_seq = '0; rise_n = 0; tdi_one_n = 0; ovl_n = 0;
        for (int i = 0; i < 5; i++) fl_n[i] = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat  = -1;
        data = '0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat  = k;
                data = rsp_data;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, busy, vji_tck, vji_tdi} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 10000", {cmd_ready, rsp_valid, busy, vji_tck, vji_tdi});
        end
        n_checks++;
        if ({vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ir_flags: got %b expected 0", {vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        end
        n_checks++;
        if (rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
        end
        n_checks++;
        if (c1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_div1: got %b expected 1", c1_ready);
        end
        reset = 1'b0;
        m_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        int p, lat;
        logic [W-1:0] d;
        logic [W-1:0] dr;
        dr = 38'h2A_5555_AAAA;
        model_accept(2'd2, p);
        run_scan(2'd2, dr, 0, lat, d);
        n_checks++;
        if (lat !== p * P) begin
            n_fail++;
            $display("FAIL loop_latency: got %0d expected %0d", lat, p * P);
        end
        n_checks++;
        if (d !== dr) begin
            n_fail++;
            $display("FAIL loop_data: got %h expected %h", d, dr);
        end
        n_checks++;
        if (vji_ir_in !== 2'd2) begin
            n_fail++;
            $display("FAIL loop_ir_in: got %0d expected 2", vji_ir_in);
        end
        n_checks++;
        if (tdi_n !== W || tdi_seq !== dr) begin
            n_fail++;
            $display("FAIL loop_tdi_serial: got %0d bits %h expected %0d bits %h", tdi_n, tdi_seq, W, dr);
        end
        n_checks++;
        if (rise_n !== p) begin
            n_fail++;
            $display("FAIL loop_tck_periods: got %0d expected %0d", rise_n, p);
        end
    endtask

    task automatic test_tdo_ones();
        int p, lat;
        logic [W-1:0] d;
        model_accept(2'd0, p);
        run_scan(2'd0, '0, 2, lat, d);
        n_checks++;
        if (d !== 38'h3F_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL ones_data: got %h expected 3fffffffff", d);
        end
        n_checks++;
        if (tdi_one_n !== 0) begin
            n_fail++;
            $display("FAIL ones_tdi_low: got %0d high cycles expected 0", tdi_one_n);
        end
        n_checks++;
        if (lat !== p * P) begin
            n_fail++;
            $display("FAIL ones_latency: got %0d expected %0d", lat, p * P);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int p, lat, mode;
            logic [1:0] ir;
            logic [W-1:0] dr, d;
            ir   = 2'($urandom_range(0, 3));
            dr   = rand_dr();
            mode = $urandom_range(0, 3);
            model_accept(ir, p);
            run_scan(ir, dr, mode, lat, d);
            n_checks++;
            if (lat !== p * P) begin
                n_fail++;
                $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, p * P);
            end
            n_checks++;
            if (d !== exp_data(dr, mode)) begin
                n_fail++;
                $display("FAIL rand%0d_data: got %h expected %h", t, d, exp_data(dr, mode));
            end
            n_checks++;
            if (tdi_seq !== dr || ovl_n !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_serial: tdi %h overlaps %0d expected tdi %h overlaps 0", t, tdi_seq, ovl_n, dr);
            end
        end
    endtask

    task automatic test_flags();
        int lat;
        int exp_fl[5];
        logic [W-1:0] dr, d;
        exp_fl = '{2, 2, 2 * W, 2, 2};
        dr = rand_dr();
        for (int i = 0; i < 5; i++) fl1_n[i] = 0;
        ovl1_n   = 0;
        c1_ir    = 2'd2;
        c1_dr    = dr;
        c1_valid = 1'b1;
        @(posedge clk); #1;
        c1_valid = 1'b0;
        lat = -1;
        d   = '0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            if (r1_valid) begin
                lat = k;
                d   = r1_data;
                break;
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (lat !== (3 + W + 1) * 2) begin
            n_fail++;
            $display("FAIL div1_latency: got %0d expected %0d", lat, (3 + W + 1) * 2);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (fl1_n[i] !== exp_fl[i]) begin
                n_fail++;
                $display("FAIL div1_flag%0d_cycles: got %0d expected %0d", i, fl1_n[i], exp_fl[i]);
            end
        end
        n_checks++;
        if (ovl1_n !== 0) begin
            n_fail++;
            $display("FAIL div1_flag_overlap: got %0d expected 0", ovl1_n);
        end
        n_checks++;
        if (d !== dr) begin
            n_fail++;
            $display("FAIL div1_data: got %h expected %h", d, dr);
        end
    endtask

    task automatic test_back_to_back();
        int pa, pb, lat_a, lat_b;
        logic [1:0] ira, irb;
        logic [W-1:0] dra, drb, da, db;
        ira = 2'($urandom_range(0, 3));
        irb = 2'($urandom_range(0, 3));
        dra = rand_dr();
        drb = rand_dr();
        tdo_mode = 0;
        model_accept(ira, pa);
        cmd_ir = ira; cmd_dr = dra; cmd_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({cmd_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_accept_a: ready,busy got %b expected 01", {cmd_ready, busy});
        end
        lat_a = -1;
        da = '0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); #1;
            // Next command is offered while the first is still busy.
            if (k == 20) begin
                cmd_ir = irb;
                cmd_dr = drb;
            end
            if (rsp_valid) begin
                lat_a = k;
                da = rsp_data;
                break;
            end
        end
        n_checks++;
        if (lat_a !== pa * P || da !== dra || vji_ir_in !== ira) begin
            n_fail++;
            $display("FAIL b2b_first: lat %0d data %h ir %0d expected lat %0d data %h ir %0d",
                     lat_a, da, vji_ir_in, pa * P, dra, ira);
        end
        model_accept(irb, pb);
        @(posedge clk); #1;
        n_checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: ready,busy,rsp got %b expected 100", {cmd_ready, busy, rsp_valid});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if ({cmd_ready, busy} !== 2'b01 || vji_ir_in !== irb) begin
            n_fail++;
            $display("FAIL b2b_accept_b: ready,busy %b ir %0d expected 01 ir %0d", {cmd_ready, busy}, vji_ir_in, irb);
        end
        lat_b = -1;
        db = '0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat_b = k;
                db = rsp_data;
                break;
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (lat_b !== pb * P || db !== drb) begin
            n_fail++;
            $display("FAIL b2b_second: lat %0d data %h expected lat %0d data %h", lat_b, db, pb * P, drb);
        end
    endtask

    task automatic test_reset_mid_sdr();
        int p, lat, rsp_seen;
        logic [1:0] ir;
        logic [W-1:0] dr, d;
        ir = 2'($urandom_range(0, 3));
        dr = rand_dr();
        tdo_mode = 0;
        model_accept(ir, p);
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        // 50 clk = period 12 (TCK_DIV=2), inside the data shift.
        repeat (50) @(posedge clk);
        #1;
        n_checks++;
        if (vji_sdr !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_in_sdr: got %b expected 1", vji_sdr);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_ir_in,
             vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 12'b1000_0000_0000 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b data %h expected 100000000000 data 0",
                     {cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_ir_in,
                      vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, rsp_data);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_vld = 1'b0;
        rsp_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) rsp_seen++;
        end
        n_checks++;
        if (rsp_seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_rsp: got %0d active cycles expected 0", rsp_seen);
        end
        dr = rand_dr();
        model_accept(ir, p);
        run_scan(ir, dr, 0, lat, d);
        n_checks++;
        if (lat !== p * P || d !== dr) begin
            n_fail++;
            $display("FAIL midreset_recover: lat %0d data %h expected lat %0d data %h", lat, d, p * P, dr);
        end
    endtask

    task automatic test_ir_cache();
        logic [1:0] irs[3];
        irs = '{2'd1, 2'd1, 2'd3};
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_vld = 1'b0;
        for (int t = 0; t < 3; t++) begin
            int p, lat;
            logic [W-1:0] dr, d;
            dr = rand_dr();
            model_accept(irs[t], p);
            run_scan(irs[t], dr, 0, lat, d);
            n_checks++;
            if (lat !== p * P || d !== dr) begin
                n_fail++;
                $display("FAIL cache%0d_scan: lat %0d data %h expected lat %0d data %h", t, lat, d, p * P, dr);
            end
            n_checks++;
            if (fl_n[0] !== ((p == 3 + W + 1) ? P : 0)) begin
                n_fail++;
                $display("FAIL cache%0d_uir_cycles: got %0d expected %0d", t, fl_n[0], (p == 3 + W + 1) ? P : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_tdo_ones();
        test_random();
        test_flags();
        test_back_to_back();
        test_reset_mid_sdr();
        test_ir_cache();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
